// File: rtl/imem_loader_pkg.sv
// imem_loader shared definitions: loader states and frame constants.
// Optional checksum trailer is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

   localparam int HDR_BYTES = 4;
   localparam int AW        = 32;

   typedef logic [2:0] state_t;

   localparam state_t S_HDR   = 3'd0;
   localparam state_t S_DATA  = 3'd1;
   localparam state_t S_CHK   = 3'd2;
   localparam state_t S_FLUSH = 3'd3;
   localparam state_t S_DONE  = 3'd4;
   localparam state_t S_ERR   = 3'd5;

endpackage

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream to byte writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import imem_loader_pkg::*;

module imem_loader #(
   parameter int MEM_BYTES = 4096,
   parameter int BASE_ADDR = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_wdata,
   output logic          cpu_hold,
   output logic          load_done,
   output logic          load_err,
   output logic [AW-1:0] bytes_loaded
);

   localparam logic [AW-1:0] BASE32 = 32'(BASE_ADDR);
   localparam logic [63:0]   BASE64 = 64'(BASE_ADDR);
   localparam logic [63:0]   MEM64  = 64'(MEM_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t TAIL = S_CHK;
`else
   localparam state_t TAIL = S_FLUSH;
`endif

   state_t          state;
   logic [AW-1:0]   len;
   logic [1:0]      hdr_cnt;
   logic [AW-1:0]   cnt;
   logic            take;
   logic [AW-1:0]   len_next;
   logic            hdr_last;
   logic            misalign;
   logic            oversize;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]      csum;
`endif

   assign take     = in_valid & in_ready;
   assign len_next = {in_data, len[AW-1:8]};
   assign hdr_last = (hdr_cnt == 2'(HDR_BYTES - 1));
   assign misalign = |len_next[1:0];
   assign oversize = ({32'd0, len_next} + BASE64) > MEM64;
   assign cpu_hold = (state != S_DONE);

   // Accept bytes in every state that consumes stream data
   always_comb begin
      in_ready = 1'b0;
      if (!rst) begin
         case (state)
            S_HDR, S_DATA, S_CHK, S_ERR: in_ready = 1'b1;
            default:                     in_ready = 1'b0;
         endcase
      end
   end

   // Frame FSM with length capture, byte counter and registered write port
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_HDR;
         len          <= '0;
         hdr_cnt      <= '0;
         cnt          <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         load_done    <= 1'b0;
         load_err     <= 1'b0;
         bytes_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_HDR: begin
               if (take) begin
                  len     <= len_next;
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (hdr_last) begin
                     cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                     csum <= '0;
`endif
                     if (misalign || oversize) begin
                        state    <= S_ERR;
                        load_err <= 1'b1;
                     end else if (len_next == '0) begin
                        state <= TAIL;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (take) begin
                  mem_we       <= 1'b1;
                  mem_addr     <= BASE32 + cnt;
                  mem_wdata    <= in_data;
                  bytes_loaded <= bytes_loaded + 32'd1;
                  cnt          <= cnt + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum         <= csum ^ in_data;
`endif
                  if (cnt == len - 32'd1) begin
                     state <= TAIL;
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (take) begin
                  if (in_data == csum) begin
                     state <= S_FLUSH;
                  end else begin
                     state    <= S_ERR;
                     load_err <= 1'b1;
                  end
               end
            end
`endif
            S_FLUSH: begin
               state     <= S_DONE;
               load_done <= 1'b1;
            end
            S_DONE: state <= S_DONE;
            S_ERR:  state <= S_ERR;
            default: begin
               state    <= S_ERR;
               load_err <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table plus corner sequences.
// Checksum sequences run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

   localparam int MEM_BYTES = 4096;
   localparam int BASE      = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        cpu_hold;
   logic        load_done;
   logic        load_err;
   logic [31:0] bytes_loaded;

   always #5 clk = ~clk;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold),
      .load_done(load_done),
      .load_err(load_err),
      .bytes_loaded(bytes_loaded)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  data;
   } wr_t;

   typedef struct {
      logic [31:0] len;
      logic        exp_err;
      int          exp_bytes;
   } vec_t;

   wr_t exp_q[$];
   int  errors = 0;
   int  checks = 0;
   int  writes = 0;
   wr_t cur;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: every write strobe must match the oldest expected write
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         writes++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            cur = exp_q.pop_front();
            check("wr_addr", mem_addr, cur.addr);
            check("wr_data", {24'd0, mem_wdata}, {24'd0, cur.data});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got no finish, expected finish within 1 ms");
      $fatal(1, "timeout");
   end

   function automatic logic [7:0] pay(input int k);
      return 8'(k * 37 + 19);
   endfunction

   function automatic logic [7:0] xsum(input logic [7:0] pl[$]);
      logic [7:0] x = 8'h00;
      foreach (pl[i]) x ^= pl[i];
      return x;
   endfunction

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      check("in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_data  = 8'($urandom);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
      check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      check("rst_load_done", {31'd0, load_done}, 32'd0);
      check("rst_load_err", {31'd0, load_err}, 32'd0);
      check("rst_bytes", bytes_loaded, 32'd0);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] len, input logic [7:0] pl[$],
                             input bit gap);
      for (int i = 0; i < 4; i++) begin
         send(len[8*i +: 8]);
         if (gap) idle(1);
      end
      for (int k = 0; k < pl.size(); k++) begin
         exp_q.push_back('{addr: 32'(BASE + k), data: pl[k]});
         send(pl[k]);
         if (gap) idle(1);
      end
   endtask

   task automatic check_end(input string tag, input logic err,
                            input int nbytes);
      check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
      check({tag, "_load_done"}, {31'd0, load_done}, {31'd0, ~err});
      check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, err});
      check({tag, "_bytes"}, bytes_loaded, 32'(nbytes));
   endtask

   vec_t       tbl[9];
   logic [7:0] pl[$];
   logic [7:0] img[$];
   int         w0;

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;

      tbl[0] = '{32'd8,          1'b0, 8};
      tbl[1] = '{32'd6,          1'b1, 0};
      tbl[2] = '{32'd4100,       1'b1, 0};
      tbl[3] = '{32'd0,          1'b0, 0};
      tbl[4] = '{32'd4,          1'b0, 4};
      tbl[5] = '{32'd2,          1'b1, 0};
      tbl[6] = '{32'd4096,       1'b0, 4096};
      tbl[7] = '{32'hFFFF_FFFC,  1'b1, 0};
      tbl[8] = '{32'd12,         1'b0, 12};

      for (int v = 0; v < 9; v++) begin
         do_reset();
         w0 = writes;
         pl = {};
         for (int k = 0; k < tbl[v].exp_bytes; k++) pl.push_back(pay(k));
         send_frame(tbl[v].len, pl, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (!tbl[v].exp_err) send(xsum(pl));
`endif
         idle(3);
         check_end($sformatf("vec%0d", v), tbl[v].exp_err, tbl[v].exp_bytes);
         check($sformatf("vec%0d_writes", v), 32'(writes - w0),
               32'(tbl[v].exp_bytes));
      end

      // Spec image: done exactly two cycles after the last accepted byte
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      do_reset();
      send_frame(32'd8, img, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(xsum(img));
`endif
      idle(1);
      check("img_t1_done", {31'd0, load_done}, 32'd0);
      check("img_t1_hold", {31'd0, cpu_hold}, 32'd1);
      idle(1);
      check("img_t2_done", {31'd0, load_done}, 32'd1);
      check("img_t2_hold", {31'd0, cpu_hold}, 32'd0);
      check("img_bytes", bytes_loaded, 32'd8);

      // Misaligned header: error next cycle, then drain with in_ready high
      do_reset();
      w0 = writes;
      pl = {};
      send_frame(32'd6, pl, 1'b0);
      idle(1);
      check("mis_err_next", {31'd0, load_err}, 32'd1);
      for (int i = 0; i < 10; i++) send(8'($urandom));
      idle(2);
      check("mis_writes", 32'(writes - w0), 32'd0);
      check("mis_hold", {31'd0, cpu_hold}, 32'd1);

      // Gapped stream gives the same writes as the contiguous one
      do_reset();
      send_frame(32'd8, img, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(xsum(img));
`endif
      idle(3);
      check_end("gap", 1'b0, 8);

      // Reset after three payload bytes, then a fresh 4-byte frame
      do_reset();
      pl = '{8'hA1, 8'hB2, 8'hC3};
      send_frame(32'd8, pl, 1'b0);
      do_reset();
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(32'd4, pl, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(xsum(pl));
`endif
      idle(3);
      check_end("rst_mid", 1'b0, 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
      pl = '{8'h13, 8'h00, 8'h00, 8'h00};
      do_reset();
      send_frame(32'd4, pl, 1'b0);
      send(8'h13);
      idle(3);
      check_end("cs_good", 1'b0, 4);
      do_reset();
      send_frame(32'd4, pl, 1'b0);
      send(8'h12);
      idle(1);
      check("cs_bad_err_next", {31'd0, load_err}, 32'd1);
      idle(2);
      check_end("cs_bad", 1'b1, 4);
`endif

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
